// File: rtl/round_key_store_pkg.sv
// Shared AES round-key store definitions.
// Key geometry defaults and the store state encoding.
package round_key_store_pkg;

  localparam int RKS_KEY_WIDTH = 128;
  localparam int RKS_NUM_KEYS  = 11;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FILL   = 2'd1,
    ST_FULL   = 2'd2,
    ST_STREAM = 2'd3
  } rks_state_t;

endpackage

// File: rtl/round_key_regfile.sv
// Round-key storage: one write port, two registered read ports.
// The array itself is not reset; read registers are.
module round_key_regfile
  import round_key_store_pkg::*;
#(
  parameter int KEY_WIDTH = RKS_KEY_WIDTH,
  parameter int NUM_KEYS  = RKS_NUM_KEYS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [3:0]           waddr,
  input  logic [KEY_WIDTH-1:0] wdata,
  input  logic                 rd_en,
  input  logic                 rd_hit,
  input  logic [3:0]           rd_addr,
  output logic [KEY_WIDTH-1:0] rd_data,
  input  logic                 st_en,
  input  logic [3:0]           st_addr,
  output logic [KEY_WIDTH-1:0] st_data
);

  logic [KEY_WIDTH-1:0] mem [NUM_KEYS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Misses return zero so unloaded entries never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_hit ? mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_data <= '0;
    end else if (st_en) begin
      st_data <= mem[st_addr];
    end
  end

endmodule

// File: rtl/round_key_store.sv
// Round-key store: in-order fill, random reads,
// and reverse-order key stream for the inverse cipher.
module round_key_store
  import round_key_store_pkg::*;
#(
  parameter int KEY_WIDTH = RKS_KEY_WIDTH,
  parameter int NUM_KEYS  = RKS_NUM_KEYS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid_i,
  input  logic [KEY_WIDTH-1:0] round_key_i,
  input  logic [3:0]           wr_round_i,
  input  logic                 clear_i,
  input  logic                 rd_req_i,
  input  logic [3:0]           rd_round_i,
  output logic [KEY_WIDTH-1:0] rd_key_o,
  output logic                 rd_valid_o,
  output logic                 rd_err_o,
  output logic                 wr_err_o,
  output logic                 full_o,
  input  logic                 stream_start_i,
  input  logic                 str_ready_i,
  output logic                 str_valid_o,
  output logic [KEY_WIDTH-1:0] str_key_o,
  output logic [3:0]           str_round_o
);

  localparam logic [3:0] LAST = 4'(NUM_KEYS - 1);

  rks_state_t state;
  logic [3:0] wr_ptr;
  logic [3:0] str_idx;

  logic busy, wr_open, in_range, loaded;
  logic rd_hit, wr_ok, wr_bad, str_fire;
  logic st_start, st_step, st_en;
  logic [3:0] st_addr;

  assign busy     = (state == ST_FULL) || (state == ST_STREAM);
  assign wr_open  = (state == ST_EMPTY) || (state == ST_FILL);
  assign in_range = 5'(rd_round_i) < 5'(NUM_KEYS);
  assign loaded   = in_range && (busy || (rd_round_i < wr_ptr));
  assign rd_hit   = rd_req_i && !clear_i && loaded;

  assign wr_ok  = key_valid_i && !clear_i && wr_open
               && (wr_round_i == wr_ptr);
  assign wr_bad = key_valid_i && !clear_i && !wr_ok;

  assign str_fire = str_valid_o && str_ready_i;
  assign st_start = !clear_i && (state == ST_FULL)
                 && stream_start_i;
  assign st_step  = !clear_i && (state == ST_STREAM)
                 && str_fire && (str_idx != 4'd0);
  assign st_en    = st_start || st_step;
  assign st_addr  = st_start ? LAST : str_idx - 4'd1;

  assign str_round_o = str_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      wr_ptr      <= '0;
      str_idx     <= '0;
      str_valid_o <= 1'b0;
      full_o      <= 1'b0;
      wr_err_o    <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_err_o    <= 1'b0;
    end else begin
      wr_err_o   <= wr_bad;
      rd_valid_o <= rd_req_i;
      rd_err_o   <= rd_req_i && !rd_hit;
      if (clear_i) begin
        state       <= ST_EMPTY;
        wr_ptr      <= '0;
        str_idx     <= '0;
        str_valid_o <= 1'b0;
        full_o      <= 1'b0;
      end else begin
        unique case (state)
          ST_EMPTY, ST_FILL: begin
            if (wr_ok) begin
              wr_ptr <= wr_ptr + 4'd1;
              if (wr_ptr == LAST) begin
                state  <= ST_FULL;
                full_o <= 1'b1;
              end else begin
                state <= ST_FILL;
              end
            end
          end
          ST_FULL: begin
            if (stream_start_i) begin
              state       <= ST_STREAM;
              str_idx     <= LAST;
              str_valid_o <= 1'b1;
            end
          end
          ST_STREAM: begin
            if (str_fire) begin
              if (str_idx == 4'd0) begin
                state       <= ST_FULL;
                str_valid_o <= 1'b0;
              end else begin
                str_idx <= str_idx - 4'd1;
              end
            end
          end
        endcase
      end
    end
  end

  round_key_regfile #(
    .KEY_WIDTH(KEY_WIDTH),
    .NUM_KEYS (NUM_KEYS)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wr_ok),
    .waddr  (wr_round_i),
    .wdata  (round_key_i),
    .rd_en  (rd_req_i),
    .rd_hit (rd_hit),
    .rd_addr(rd_round_i),
    .rd_data(rd_key_o),
    .st_en  (st_en),
    .st_addr(st_addr),
    .st_data(str_key_o)
  );

endmodule

// File: tb/tb_round_key_store.sv
// Bench for round_key_store: vector table for fill/read,
// scripted stream, clear and reset sequences.
module tb_round_key_store;

  logic         clk;
  logic         rst_n;
  logic         key_valid_i;
  logic [127:0] round_key_i;
  logic [3:0]   wr_round_i;
  logic         clear_i;
  logic         rd_req_i;
  logic [3:0]   rd_round_i;
  logic [127:0] rd_key_o;
  logic         rd_valid_o;
  logic         rd_err_o;
  logic         wr_err_o;
  logic         full_o;
  logic         stream_start_i;
  logic         str_ready_i;
  logic         str_valid_o;
  logic [127:0] str_key_o;
  logic [3:0]   str_round_o;

  round_key_store dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_valid_i   (key_valid_i),
    .round_key_i   (round_key_i),
    .wr_round_i    (wr_round_i),
    .clear_i       (clear_i),
    .rd_req_i      (rd_req_i),
    .rd_round_i    (rd_round_i),
    .rd_key_o      (rd_key_o),
    .rd_valid_o    (rd_valid_o),
    .rd_err_o      (rd_err_o),
    .wr_err_o      (wr_err_o),
    .full_o        (full_o),
    .stream_start_i(stream_start_i),
    .str_ready_i   (str_ready_i),
    .str_valid_o   (str_valid_o),
    .str_key_o     (str_key_o),
    .str_round_o   (str_round_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       kv;
    bit [3:0] wr;
    bit       rq;
    bit [3:0] rr;
    bit       rerr;
    bit       werr;
    bit       full;
  } vec_t;

  typedef struct {
    bit           err;
    logic [127:0] key;
  } rd_exp_t;

  logic [127:0] rk [11];
  vec_t         tbl [15];
  rd_exp_t      sbq [$];
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push_rd(input logic [3:0] idx, input bit err);
    rd_exp_t e;
    e.err = err;
    if (err) e.key = '0;
    else     e.key = rk[idx];
    sbq.push_back(e);
    rd_req_i   = 1'b1;
    rd_round_i = idx;
  endtask

  task automatic wr(input logic [3:0] idx);
    key_valid_i = 1'b1;
    wr_round_i  = idx;
    round_key_i = (idx < 4'd11) ? rk[idx] : 128'h0;
  endtask

  task automatic tick();
    rd_exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("rd_valid", 128'(rd_valid_o), 128'd1);
      chk("rd_err", 128'(rd_err_o), 128'(e.err));
      chk("rd_key", rd_key_o, e.key);
    end else begin
      chk("rd_idle", 128'({rd_valid_o, rd_err_o}), 128'd0);
    end
    key_valid_i    = 1'b0;
    rd_req_i       = 1'b0;
    clear_i        = 1'b0;
    stream_start_i = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rd_key"}, rd_key_o, 128'd0);
    chk({nm, "_flags"},
        128'({rd_valid_o, rd_err_o, wr_err_o, full_o, str_valid_o}),
        128'd0);
    chk({nm, "_str_key"}, str_key_o, 128'd0);
    chk({nm, "_str_round"}, 128'(str_round_o), 128'd0);
  endtask

  initial begin
    int  e;
    bit  done;
    bit  rdy;

    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    //            kv wr  rq rr  rerr werr full
    tbl[0]  = '{1, 0,  1, 0,  1, 0, 0};
    tbl[1]  = '{1, 1,  1, 0,  0, 0, 0};
    tbl[2]  = '{1, 2,  1, 15, 1, 0, 0};
    tbl[3]  = '{1, 5,  1, 3,  1, 1, 0};
    tbl[4]  = '{0, 0,  1, 2,  0, 0, 0};
    tbl[5]  = '{1, 3,  1, 3,  1, 0, 0};
    tbl[6]  = '{1, 4,  1, 4,  1, 0, 0};
    tbl[7]  = '{1, 5,  1, 4,  0, 0, 0};
    tbl[8]  = '{1, 6,  0, 0,  0, 0, 0};
    tbl[9]  = '{1, 7,  0, 0,  0, 0, 0};
    tbl[10] = '{1, 8,  0, 0,  0, 0, 0};
    tbl[11] = '{1, 9,  0, 0,  0, 0, 0};
    tbl[12] = '{1, 10, 0, 0,  0, 0, 1};
    tbl[13] = '{1, 0,  1, 10, 0, 1, 1};
    tbl[14] = '{0, 0,  1, 11, 1, 0, 1};

    rst_n          = 1'b0;
    key_valid_i    = 1'b0;
    round_key_i    = '0;
    wr_round_i     = '0;
    clear_i        = 1'b0;
    rd_req_i       = 1'b0;
    rd_round_i     = '0;
    stream_start_i = 1'b0;
    str_ready_i    = 1'b0;

    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].kv) wr(4'(tbl[i].wr));
      if (tbl[i].rq) push_rd(4'(tbl[i].rr), tbl[i].rerr);
      tick();
      chk($sformatf("v%0d_wr_err", i), 128'(wr_err_o),
          128'(tbl[i].werr));
      chk($sformatf("v%0d_full", i), 128'(full_o),
          128'(tbl[i].full));
    end

    // reverse stream with ready pattern 1,0,1,1,...
    stream_start_i = 1'b1;
    tick();
    chk("st_valid0", 128'(str_valid_o), 128'd1);
    chk("st_round0", 128'(str_round_o), 128'd10);
    chk("st_key0", str_key_o, rk[10]);
    e    = 10;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      rdy = (c != 1);
      str_ready_i = rdy;
      if (c == 3) push_rd(4'd7, 1'b0);
      tick();
      if (rdy && e == 0) begin
        done = 1'b1;
        chk("st_end_valid", 128'(str_valid_o), 128'd0);
        chk("st_end_full", 128'(full_o), 128'd1);
      end else begin
        if (rdy) e--;
        chk($sformatf("st_c%0d_valid", c), 128'(str_valid_o), 128'd1);
        chk($sformatf("st_c%0d_round", c), 128'(str_round_o),
            128'(e));
        chk($sformatf("st_c%0d_key", c), str_key_o, rk[e]);
      end
    end
    str_ready_i = 1'b0;
    if (!done) chk("st_timeout", 128'd0, 128'd1);

    // clear mid-stream at index 6, with a read pending
    stream_start_i = 1'b1;
    tick();
    str_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    str_ready_i = 1'b0;
    chk("cl_round", 128'(str_round_o), 128'd6);
    chk("cl_key", str_key_o, rk[6]);
    clear_i = 1'b1;
    push_rd(4'd3, 1'b1);
    tick();
    chk("cl_valid", 128'(str_valid_o), 128'd0);
    chk("cl_full", 128'(full_o), 128'd0);
    stream_start_i = 1'b1;
    tick();
    chk("cl_nostart", 128'(str_valid_o), 128'd0);
    wr(4'd0);
    tick();
    chk("cl_wr0", 128'(wr_err_o), 128'd0);
    wr(4'd1);
    push_rd(4'd0, 1'b0);
    tick();
    chk("cl_wr1", 128'(wr_err_o), 128'd0);
    push_rd(4'd2, 1'b1);
    tick();

    // asynchronous reset mid-fill
    wr(4'd2);
    push_rd(4'd1, 1'b0);
    tick();
    rst_n = 1'b0;
    #2;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wr(4'd3);
    tick();
    chk("rr_wr3_err", 128'(wr_err_o), 128'd1);
    wr(4'd0);
    tick();
    chk("rr_wr0_ok", 128'(wr_err_o), 128'd0);
    push_rd(4'd0, 1'b0);
    tick();
    push_rd(4'd1, 1'b1);
    tick();
    chk("rr_full", 128'(full_o), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_key_store.md
ROUND_KEY_STORE -- requirements
Module: round_key_store

Interface
REQ-001 Parameter KEY_WIDTH, default 128, width of one round key.
REQ-002 Parameter NUM_KEYS, default 11, number of round keys held (indices 0..NUM_KEYS-1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 key_valid_i  input  1  round_key_i/wr_round_i carry a key this cycle.
REQ-006 round_key_i  input  KEY_WIDTH  round key from the key expansion stage, {w0,w1,w2,w3}.
REQ-007 wr_round_i  input  4  round index of round_key_i.
REQ-008 clear_i  input  1  synchronous flush of all loaded entries.
REQ-009 rd_req_i  input  1  random-access read request.
REQ-010 rd_round_i  input  4  index to read.
REQ-011 rd_key_o  output  KEY_WIDTH  registered read data.
REQ-012 rd_valid_o  output  1  rd_key_o valid this cycle.
REQ-013 rd_err_o  output  1  read index out of range or not yet loaded.
REQ-014 wr_err_o  output  1  one-cycle pulse: write rejected.
REQ-015 full_o  output  1  all NUM_KEYS entries loaded.
REQ-016 stream_start_i  input  1  start reverse-order key stream for inverse cipher.
REQ-017 str_ready_i  input  1  consumer accepts str_key_o this cycle.
REQ-018 str_valid_o / str_key_o / str_round_o  output  1 / KEY_WIDTH / 4  streamed key, valid flag, its index.

Function
REQ-019 States SHALL be EMPTY, FILL, FULL, STREAM; wr_ptr (4 bits) counts accepted writes.
REQ-020 A write SHALL be accepted when key_valid_i=1, state is EMPTY or FILL, and wr_round_i==wr_ptr; entry wr_ptr stored, wr_ptr+1.
REQ-021 EMPTY->FILL on first accepted write; FILL->FULL on the write of index NUM_KEYS-1; full_o=1 in FULL and STREAM only.
REQ-022 key_valid_i=1 with index mismatch, or in FULL/STREAM, SHALL be discarded and wr_err_o pulse high the next cycle.
REQ-023 Entry i is loaded when i<wr_ptr or state is FULL/STREAM.
REQ-024 rd_req_i SHALL be serviced in every state: next cycle rd_valid_o=1; loaded index gives rd_key_o=entry, rd_err_o=0; index>=NUM_KEYS or unloaded gives rd_key_o=0, rd_err_o=1.
REQ-025 Read and write of the same index in one cycle: read SHALL see pre-write state (unloaded -> rd_err_o=1).
REQ-026 rd_valid_o/rd_err_o SHALL be low in cycles following no rd_req_i; rd_key_o holds last value.
REQ-027 stream_start_i SHALL be honoured only in FULL: FULL->STREAM, str_round_o=NUM_KEYS-1, str_valid_o=1 the next cycle; ignored otherwise.
REQ-028 In STREAM, on str_valid_o&str_ready_i index SHALL decrement and key update next cycle; str_key_o/str_round_o SHALL stay stable while str_ready_i=0.
REQ-029 Acceptance of index 0 SHALL drop str_valid_o and return to FULL; random reads remain available during STREAM.
REQ-030 clear_i SHALL override all other inputs: next cycle state EMPTY, wr_ptr=0, str_valid_o=0, full_o=0; pending read in the same cycle returns rd_err_o=1; storage contents need not be erased.
REQ-031 Latency: write-to-readable 1 cycle; read 1 cycle; stream start 1 cycle; throughput 1 key/cycle.

Reset
REQ-032 rst_n low SHALL asynchronously force state EMPTY, wr_ptr 0, stream index 0, and all outputs to 0.
REQ-033 Key storage array SHALL NOT require reset; unloaded entries are never visible on outputs.
REQ-034 Reset asserted mid-FILL or mid-STREAM SHALL abort the operation; after release the block behaves as freshly reset.

Structure
REQ-035 KEY_WIDTH, NUM_KEYS and the state encoding SHALL live in the shared AES package.
REQ-036 Storage SHALL be one sub-module, round_key_regfile: one write port, two registered read ports (random, stream).

Verification
REQ-037 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, write indices 0..10 -> full_o=1 after write 10; read 10 returns d014f9a8c9ee2589e13f0cc8b6630ca6, rd_err_o=0.
REQ-038 After writes 0..2, write index 5 -> discarded, wr_err_o pulse; read 3 -> rd_err_o=1, rd_key_o=0; read 15 -> rd_err_o=1.
REQ-039 FULL, stream_start_i, str_ready_i toggled 1,0,1,1... -> str_round_o 10..0 in order, each key held while not ready, return to FULL after index 0.
REQ-040 Same-cycle write and read of index 4 -> rd_err_o=1; read 4 next cycle -> stored key.
REQ-041 clear_i during STREAM at index 6 -> str_valid_o=0, full_o=0, state EMPTY next cycle; rst_n pulsed mid-FILL -> all outputs 0, wr_ptr restarts at 0.
